// File: rtl/pe_pkg.sv
// Shared types and helpers for the MAC processing element.
//   pe_state_t      : accumulation FSM state (IDLE / RUN)
//   pe_sat_hi/lo    : accumulator bounds for a given width and arithmetic mode
package pe_pkg;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    RUN  = 1'b1
  } pe_state_t;

  // Bounds are returned as wide signed values; callers truncate to their own width.
  localparam int unsigned BOUND_W = 64;

  // Largest representable accumulator value.
  function automatic logic signed [BOUND_W-1:0] pe_sat_hi(input int unsigned acc_w,
                                                          input logic is_signed);
    logic signed [BOUND_W-1:0] one;
    one = 64'sd1;
    return is_signed ? (one <<< (acc_w - 1)) - one : (one <<< acc_w) - one;
  endfunction

  // Smallest representable accumulator value.
  function automatic logic signed [BOUND_W-1:0] pe_sat_lo(input int unsigned acc_w,
                                                          input logic is_signed);
    logic signed [BOUND_W-1:0] one;
    one = 64'sd1;
    return is_signed ? -(one <<< (acc_w - 1)) : 64'sd0;
  endfunction

endpackage

// File: rtl/pe_mac_acc.sv
// Accumulate stage of the MAC PE: extends each product, adds it to the running
// sum, detects overflow against the mode's bounds, clamps or wraps, keeps a
// sticky overflow bit and registers the final sum as a one-cycle result.
// Ports:
//   p_vld/p_first/p_last/p_signed/p_prod : registered product beat
//   res_vld/res_data/res_ovf             : result strobe, sum, overflow flag
module pe_mac_acc
  import pe_pkg::*;
#(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned ACC_W  = 24,
  parameter int unsigned SAT_EN = 1
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                p_vld,
  input  logic                p_first,
  input  logic                p_last,
  input  logic                p_signed,
  input  logic [2*DATA_W-1:0] p_prod,
  output logic                res_vld,
  output logic [ACC_W-1:0]    res_data,
  output logic                res_ovf
);

  localparam int unsigned PROD_W = 2 * DATA_W;
  // Two guard bits: the unsigned sum needs ACC_W+1 magnitude bits plus a sign.
  localparam int unsigned SUM_W  = ACC_W + 2;

  logic [ACC_W-1:0]        acc_q, acc_d;
  logic                    ovf_q, ovf_d;
  logic                    fin_q, fin_d;
  logic                    res_vld_q;
  logic [ACC_W-1:0]        res_data_q;
  logic                    res_ovf_q;
  logic signed [SUM_W-1:0] base_c, prod_c, sum_c, hi_c, lo_c;
  logic                    acc_sx_c, prod_sx_c, hit_c;

  // Extend, add, range check and clamp/wrap.
  always_comb begin
    acc_sx_c  = p_signed & acc_q[ACC_W-1];
    prod_sx_c = p_signed & p_prod[PROD_W-1];
    base_c    = p_first ? '0 : $signed({{2{acc_sx_c}}, acc_q});
    prod_c    = $signed({{(SUM_W-PROD_W){prod_sx_c}}, p_prod});
    sum_c     = base_c + prod_c;
    hi_c      = SUM_W'(pe_sat_hi(ACC_W, p_signed));
    lo_c      = SUM_W'(pe_sat_lo(ACC_W, p_signed));
    hit_c     = 1'b0;
    acc_d     = acc_q;
    ovf_d     = ovf_q;
    fin_d     = p_vld & p_last;
    if (p_vld) begin
      acc_d = sum_c[ACC_W-1:0];
      if (sum_c > hi_c) begin
        hit_c = 1'b1;
        if (SAT_EN != 0) acc_d = hi_c[ACC_W-1:0];
      end else if (sum_c < lo_c) begin
        hit_c = 1'b1;
        if (SAT_EN != 0) acc_d = lo_c[ACC_W-1:0];
      end
      ovf_d = (ovf_q & ~p_first) | hit_c;
    end
  end

  // Accumulator state, then result register one cycle behind it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_q      <= '0;
      ovf_q      <= 1'b0;
      fin_q      <= 1'b0;
      res_vld_q  <= 1'b0;
      res_data_q <= '0;
      res_ovf_q  <= 1'b0;
    end else begin
      acc_q     <= acc_d;
      ovf_q     <= ovf_d;
      fin_q     <= fin_d;
      res_vld_q <= fin_q;
      if (fin_q) begin
        res_data_q <= acc_q;
        res_ovf_q  <= ovf_q;
      end
    end
  end

  assign res_vld  = res_vld_q;
  assign res_data = res_data_q;
  assign res_ovf  = res_ovf_q;

endmodule

// File: rtl/pe_mac.sv
// Output-stationary multiply-accumulate PE for the systolic array.
// Forwards both operand streams east/south with one cycle of delay, multiplies
// matched operand pairs and accumulates them into a local dot product.
// Ports:
//   in0_*/in1_*   : operand streams A/B          out0_*/out1_* : forwarded copies
//   pe_en         : MAC enable (not forwarding)  signed_en     : mode, latched on first beat
//   acc_clr/last  : accumulation framing         pe_doing      : busy
//   res_vld/res_data/res_ovf : result strobe, sum, overflow
module pe_mac
  import pe_pkg::*;
#(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned ACC_W  = 24,
  parameter int unsigned SAT_EN = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in0_vld,
  input  logic [DATA_W-1:0] in0_data,
  input  logic              in1_vld,
  input  logic [DATA_W-1:0] in1_data,
  input  logic              pe_en,
  input  logic              signed_en,
  input  logic              acc_clr,
  input  logic              acc_last,
  output logic              out0_vld,
  output logic [DATA_W-1:0] out0_data,
  output logic              out1_vld,
  output logic [DATA_W-1:0] out1_data,
  output logic              pe_doing,
  output logic              res_vld,
  output logic [ACC_W-1:0]  res_data,
  output logic              res_ovf
);

  localparam int unsigned PROD_W = 2 * DATA_W;

  pe_state_t          state_q, state_d;
  logic               out0_vld_q, out1_vld_q;
  logic [DATA_W-1:0]  out0_data_q, out1_data_q;
  logic               mode_q;
  logic               p_vld_q, p_first_q, p_last_q, p_signed_q;
  logic [PROD_W-1:0]  p_prod_q;
  logic               fire_c, first_c, eff_signed_c;
  logic signed [PROD_W-1:0] prod_s_c;
  logic [PROD_W-1:0]  prod_u_c;

  assign fire_c = in0_vld & in1_vld & pe_en;

  // Operand forwarding: valid every cycle, data only on valid.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out0_vld_q  <= 1'b0;
      out1_vld_q  <= 1'b0;
      out0_data_q <= '0;
      out1_data_q <= '0;
    end else begin
      out0_vld_q <= in0_vld;
      out1_vld_q <= in1_vld;
      if (in0_vld) out0_data_q <= in0_data;
      if (in1_vld) out1_data_q <= in1_data;
    end
  end

  // FSM state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // FSM next state; an abort (clr without last) in RUN stays in RUN.
  always_comb begin
    state_d = state_q;
    if (fire_c) begin
      case (state_q)
        IDLE:    state_d = acc_last ? IDLE : RUN;
        RUN:     state_d = acc_last ? IDLE : RUN;
        default: state_d = IDLE;
      endcase
    end
  end

  // FSM outputs: any fire in IDLE starts a fresh accumulation.
  always_comb begin
    first_c      = fire_c & ((state_q == IDLE) | acc_clr);
    eff_signed_c = first_c ? signed_en : mode_q;
    pe_doing     = (state_q == RUN) | p_vld_q;
  end

  assign prod_s_c = $signed({{DATA_W{in0_data[DATA_W-1]}}, in0_data}) *
                    $signed({{DATA_W{in1_data[DATA_W-1]}}, in1_data});
  assign prod_u_c = {{DATA_W{1'b0}}, in0_data} * {{DATA_W{1'b0}}, in1_data};

  // Stage P: product register plus beat framing and mode latch.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mode_q     <= 1'b0;
      p_vld_q    <= 1'b0;
      p_first_q  <= 1'b0;
      p_last_q   <= 1'b0;
      p_signed_q <= 1'b0;
      p_prod_q   <= '0;
    end else begin
      p_vld_q <= fire_c;
      if (first_c) mode_q <= signed_en;
      if (fire_c) begin
        p_first_q  <= first_c;
        p_last_q   <= acc_last;
        p_signed_q <= eff_signed_c;
        p_prod_q   <= eff_signed_c ? PROD_W'(prod_s_c) : prod_u_c;
      end
    end
  end

  pe_mac_acc #(
    .DATA_W (DATA_W),
    .ACC_W  (ACC_W),
    .SAT_EN (SAT_EN)
  ) u_acc (
    .clk      (clk),
    .rst_n    (rst_n),
    .p_vld    (p_vld_q),
    .p_first  (p_first_q),
    .p_last   (p_last_q),
    .p_signed (p_signed_q),
    .p_prod   (p_prod_q),
    .res_vld  (res_vld),
    .res_data (res_data),
    .res_ovf  (res_ovf)
  );

  assign out0_vld  = out0_vld_q;
  assign out0_data = out0_data_q;
  assign out1_vld  = out1_vld_q;
  assign out1_data = out1_data_q;

endmodule

// File: doc/pe_mac.md
# pe_mac

Parametrised output-stationary multiply-accumulate processing element for the systolic array. It forwards both operand streams to its east and south neighbours with one cycle of delay, multiplies matched operand pairs, and accumulates the products over a programmable-length dot product. At the final beat it emits the sum, with optional saturation, selectable signed or unsigned arithmetic and an overflow flag. It replaces the single-product PE wherever the array keeps partial sums local.

## Interface
- DATA_W, 8: operand width.
- ACC_W, 24: accumulator/result width; must be ≥ 2*DATA_W.
- SAT_EN, 1: 1 = saturate on overflow, 0 = wrap.

Ports:
- clk  in  1  clock; the only clock.
- rst_n  in  1  asynchronous active-low reset.
- in0_vld  in  1  operand A valid.
- in0_data  in  DATA_W  operand A.
- in1_vld  in  1  operand B valid.
- in1_data  in  DATA_W  operand B.
- pe_en  in  1  enables MAC consumption; forwarding is independent of it.
- signed_en  in  1  1 = two's-complement operands; sampled on the first beat.
- acc_clr  in  1  marks a beat as the first of a new accumulation.
- acc_last  in  1  marks a beat as the last of an accumulation.
- out0_vld / out0_data  out  1 / DATA_W  operand A forwarded.
- out1_vld / out1_data  out  1 / DATA_W  operand B forwarded.
- pe_doing  out  1  busy indication.
- res_vld  out  1  one-cycle result strobe.
- res_data  out  ACC_W  accumulated result.
- res_ovf  out  1  overflow/saturation occurred in this accumulation.

## Operation
- **Beat.**
  - fire = in0_vld & in1_vld & pe_en.
  - acc_clr, acc_last and signed_en are qualified only by fire.
- **Forwarding.**
  - outN_vld <= inN_vld every cycle, regardless of pe_en.
  - outN_data loads inN_data only when inN_vld = 1, otherwise holds.
- **Stage P (registered on fire).**
  - Product of width 2*DATA_W: signed or unsigned multiply per the effective mode.
  - Registered with p_vld, p_first, p_last.
- **Stage A.**
  - When p_vld: acc <= (p_first ? 0 : acc) + ext(product).
  - ext is sign-extension in signed mode, zero-extension in unsigned mode, to ACC_W+1 bits for overflow detection.
- **Overflow.**
  - Signed mode bounds: [−2^(ACC_W−1), 2^(ACC_W−1)−1].
  - Unsigned mode bounds: [0, 2^ACC_W−1].
  - On overflow, the sticky ovf bit is set. With SAT_EN=1 the accumulator clamps to the violated bound; with SAT_EN=0 it wraps.
  - ovf clears on p_first.
- **Result.**
  - When p_vld & p_last: res_data <= final acc value, res_ovf <= final ovf, res_vld = 1 for exactly one cycle.
  - res_data and res_ovf hold until the next result.
- **Mode latch.**
  - signed_en is captured on the first beat of an accumulation.
  - Later beats use the latched mode.
- **FSM (pe_pkg state type).**
  - IDLE: no open accumulation.
    - A fire with acc_last = 0 goes to RUN.
    - A fire with acc_last = 1 is a single-beat accumulation and stays in IDLE.
    - Every fire in IDLE is treated as first, whatever acc_clr is.
  - RUN: accumulation open.
    - fire & acc_last goes to IDLE.
    - fire & acc_clr & !acc_last aborts: the partial sum is discarded, no res_vld, the beat starts a new accumulation, and the FSM stays in RUN.
    - fire & acc_clr & acc_last is a single-beat accumulation that replaces the partial sum and goes to IDLE.
- **Busy.**
  - pe_doing = (state == RUN) | p_vld.

## Timing
- Reset: every output is 0. Internal state: acc = 0, ovf = 0, p_vld = 0, state = IDLE.
- Forward latency is 1 cycle.
- MAC result latency: res_vld is asserted 2 cycles after the clock edge that samples the last beat.
- Throughput is one beat per cycle with no stalls. There is no backpressure; consumers must sample res_vld.
- Back-to-back accumulations (last at cycle t, first at t+1) produce independent results at t+2 and t+3.
- Reset mid-accumulation drops all in-flight beats. No result is emitted.
- pe_en low mid-accumulation only inserts bubbles. The accumulation stays open.

## Structure
- pe_pkg holds:
  - the pe_state_t enum (IDLE, RUN);
  - the saturation bound helper functions, parameterised by ACC_W and signed mode.
- Sub-module pe_mac_acc:
  - contains stage A (extend, add, overflow detect, clamp, sticky ovf);
  - the top level keeps forwarding, stage P and the FSM.

## Test plan
All scenarios use DATA_W=8, ACC_W=20, SAT_EN=1 unless noted.
- **Reset:** assert rst_n=0 mid-traffic → all outputs read 0 immediately; after release, the first res_vld follows only a fresh beat sequence.
- **Unsigned dot product:** beats (3,4), (5,6), (255,255), (1,1), with clr on the first and last on the fourth → res_data=65068, res_ovf=0, res_vld 1 cycle, 2 cycles after the last beat.
- **Signed dot product:** signed_en=1, beats (0xFE,0x03), (0x80,0x80) with last on the second → res_data=16378.
- **Saturation, unsigned:** 17 beats of (255,255) → res_data=1048575, res_ovf=1. With SAT_EN=0 → res_data=56849 (1105425 mod 2^20), res_ovf=1.
- **Forwarding and bubbles:** in0_vld=1 with in1_vld=0, and pe_en=0 cycles interleaved → out0 mirrors in0 one cycle later, accumulation unaffected, pe_doing stays 1 while in RUN.
- **Abort and back-to-back:**
  - (2,2), then acc_clr with (1,1), then last with (1,1) → single res_data=2.
  - A last beat followed immediately by a single-beat (7,7) → res_data=49 on the next cycle.
